// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types, funct3 encodings and access-check helpers for the
// load/store unit.
//   lsu_state_e    : load/store unit FSM states
//   F3_*           : RV32I load/store size/sign encodings (stores alias loads)
//   is_misaligned  : 1 when the access size does not fit the byte offset
//   is_illegal_f3  : 1 for funct3 encodings with no load/store meaning
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = F3_LB;
    localparam logic [2:0] F3_SH  = F3_LH;
    localparam logic [2:0] F3_SW  = F3_LW;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        case (f3)
            F3_LH, F3_LHU: mis = lo[0];
            F3_LW:         mis = (lo != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

    // 011, 110 and 111 have no load/store meaning in RV32I.
    function automatic logic is_illegal_f3(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane steering for the load/store unit.
//   funct3     : access size/sign (RV32I encoding)
//   addr_lo    : byte offset within the word
//   wdata      : store data, value in the low bits
//   rdata      : word returned by the bus
//   be         : byte enables for the addressed lanes
//   lane_wdata : store data replicated across all lanes of its size
//   load_data  : selected byte/half/word, sign- or zero-extended
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Shift the addressed byte down to lane 0; halves only ever sit at 0 or 2.
    assign shifted  = rdata >> {addr_lo, 3'b000};
    assign sel_byte = shifted[7:0];
    assign sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be         = 4'b1111;
        lane_wdata = wdata;
        // funct3[2] only selects signedness, so size comes from the low bits.
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                lane_wdata = {2{wdata[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                lane_wdata = wdata;
            end
        endcase
    end

    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU:  load_data = {24'h0, sel_byte};
            F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
            F3_LHU:  load_data = {16'h0, sel_half};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store unit between the single-cycle
// datapath and a handshaked data-memory bus.
//   clk, srst                 : clock, asynchronous active-high reset
//   req_valid, mem_w, funct3  : access request from the controller
//   addr, wdata               : effective byte address and store data
//   read_data                 : registered, extended load result
//   stall                     : hold PC/instruction, suppress register write
//   access_err                : one-cycle pulse (misaligned, illegal, timeout)
//   bus_req/we/addr/be/wdata  : registered bus request
//   bus_gnt, bus_rvalid, rdata: bus responses
//   dbg_state                 : current FSM state for observation
//
// Bus handshake: bus_req and its payload are held constant from REQ entry
// until the cycle bus_gnt is seen high; the request is taken in that cycle.
// bus_rvalid qualifies bus_rdata for a load and may come with bus_gnt or any
// later cycle; rvalid outside REQ/WAIT is ignored.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        req_valid,
    input  logic        mem_w,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        access_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output lsu_state_e  dbg_state
);

    localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

    lsu_state_e  state;
    logic [1:0]  lat_lo;
    logic [2:0]  lat_f3;
    logic [31:0] wd_cnt;

    logic        bad_access;
    logic        wd_expired;
    logic [2:0]  al_f3;
    logic [1:0]  al_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;

    assign bad_access = is_illegal_f3(funct3) | is_misaligned(funct3, addr[1:0]);
    // wd_cnt is the number of REQ/WAIT cycles already spent; this cycle is
    // the last one allowed. ">=" covers a gnt landing exactly on the limit.
    assign wd_expired = (TIMEOUT != 0) && (wd_cnt >= WD_LAST);

    // Lane steering sees the live request in IDLE (store lanes are latched
    // on the way out) and the latched access afterwards (load extraction).
    assign al_f3 = (state == IDLE) ? funct3    : lat_f3;
    assign al_lo = (state == IDLE) ? addr[1:0] : lat_lo;

    lsu_align u_align (
        .funct3     (al_f3),
        .addr_lo    (al_lo),
        .wdata      (wdata),
        .rdata      (bus_rdata),
        .be         (al_be),
        .lane_wdata (al_wdata),
        .load_data  (al_load)
    );

    // Combinational so the PC is held in the request cycle itself.
    assign stall = ((state == IDLE) && req_valid && !bad_access)
                 || (state == REQ) || (state == WAIT);

    assign dbg_state = state;

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state      <= IDLE;
            read_data  <= '0;
            access_err <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
            lat_lo     <= '0;
            lat_f3     <= '0;
            wd_cnt     <= '0;
        end else begin
            access_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (bad_access) begin
                            access_err <= 1'b1;
                            read_data  <= '0;
                        end else begin
                            state     <= REQ;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_w;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= al_be;
                            bus_wdata <= al_wdata;
                            lat_lo    <= addr[1:0];
                            lat_f3    <= funct3;
                            wd_cnt    <= '0;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        wd_cnt  <= wd_cnt + 32'd1;
                        if (bus_we) begin
                            state <= DONE;
                        end else if (bus_rvalid) begin
                            read_data <= al_load;
                            state     <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (wd_expired) begin
                        bus_req    <= 1'b0;
                        access_err <= 1'b1;
                        read_data  <= '0;
                        state      <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
                end
                WAIT: begin
                    if (bus_rvalid) begin
                        read_data <= al_load;
                        state     <= DONE;
                    end else if (wd_expired) begin
                        access_err <= 1'b1;
                        read_data  <= '0;
                        state      <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
                end
                // One non-stalled cycle so the core retires; any req_valid
                // seen here belongs to the retiring instruction.
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import riscv_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        srst;
    logic        req_valid;
    logic        mem_w;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] read_data;
    logic        stall;
    logic        access_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    lsu_state_e  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rd;
    logic [31:0] exp_q[$];

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .srst       (srst),
        .req_valid  (req_valid),
        .mem_w      (mem_w),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .read_data  (read_data),
        .stall      (stall),
        .access_err (access_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic        bad;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic [31:0] baddr;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs[$];

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rdat, input int gd,
                                input int rvd, input logic bad, input logic [3:0] be,
                                input logic [31:0] bwd, input logic [31:0] rd);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rdat;
        v.gnt_dly = gd; v.rv_dly = rvd; v.bad = bad; v.be = be; v.bwdata = bwd;
        v.baddr = {a[31:2], 2'b00}; v.rd = rd;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic run_vec(input vec_t v);
        int   n;
        int   stall_cnt;
        logic done;
        logic [31:0] got;
        @(negedge clk);
        req_valid = 1'b1; mem_w = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        #1;
        check("stall_in_request_cycle", 32'(stall), 32'(!v.bad));
        if (v.bad) begin
            @(negedge clk);
            exp_rd = 32'h0;
            check("bad_access_err", 32'(access_err), 32'h1);
            check("bad_no_bus_req", 32'(bus_req), 32'h0);
            check("bad_state_idle", 32'(dbg_state), 32'(IDLE));
            check("bad_read_data", read_data, exp_rd);
            req_valid = 1'b0;
            @(negedge clk);
            check("bad_err_pulse_end", 32'(access_err), 32'h0);
            check("bad_stall_low", 32'(stall), 32'h0);
            return;
        end
        stall_cnt = 1;
        n = 0;
        done = 1'b0;
        if (!v.we) exp_q.push_back(v.rd);
        @(negedge clk);
        check("req_bus_req", 32'(bus_req), 32'h1);
        check("req_bus_we", 32'(bus_we), 32'(v.we));
        check("req_bus_addr", bus_addr, v.baddr);
        if (v.we) begin
            check("req_bus_be", 32'(bus_be), 32'(v.be));
            check("req_bus_wdata", bus_wdata, v.bwdata);
        end
        for (int budget = 0; budget < 20 && !done; budget++) begin
            if (dbg_state == DONE) begin
                done = 1'b1;
            end else begin
                if (stall) stall_cnt++;
                if (dbg_state == REQ) check("req_hold_addr", bus_addr, v.baddr);
                bus_gnt    = (n == v.gnt_dly);
                bus_rvalid = !v.we && (n == v.gnt_dly + v.rv_dly);
                bus_rdata  = bus_rvalid ? v.rdata : 32'h5555_5555;
                @(negedge clk);
                bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h5555_5555;
                n++;
            end
        end
        check("reached_done", 32'(done), 32'h1);
        check("done_stall_low", 32'(stall), 32'h0);
        check("done_no_err", 32'(access_err), 32'h0);
        check("stall_cycles", 32'(stall_cnt), 32'(2 + v.gnt_dly + (v.we ? 0 : v.rv_dly)));
        if (!v.we) begin
            got = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            exp_rd = got;
        end
        check("read_data", read_data, exp_rd);
        req_valid = 1'b0;
        @(negedge clk);
        check("back_to_idle", 32'(dbg_state), 32'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int req_cnt;
        srst = 1'b1; req_valid = 1'b0; mem_w = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        bus_rdata = 32'h5555_5555; exp_rd = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_read_data", read_data, 32'h0);
        check("rst_bus_req", 32'(bus_req), 32'h0);
        check("rst_bus_we", 32'(bus_we), 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_be", 32'(bus_be), 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_access_err", 32'(access_err), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        srst = 1'b0;

        //            we    f3      addr          wdata         rdata         gd rv bad  be       bwdata        rd
        vecs.push_back(mk(1'b1, F3_SW,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0));
        vecs.push_back(mk(1'b1, F3_SB,  32'h0000_0103, 32'h0000_00A5, 32'h0,        0, 0, 1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0));
        vecs.push_back(mk(1'b1, F3_SH,  32'h0000_0106, 32'h1234_BEEF, 32'h0,        2, 0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0));
        vecs.push_back(mk(1'b0, F3_LB,  32'h0000_0202, 32'h0,         32'h12F0_3456, 0, 2, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FFF0));
        vecs.push_back(mk(1'b0, F3_LBU, 32'h0000_0202, 32'h0,         32'h12F0_3456, 0, 2, 1'b0, 4'b0000, 32'h0, 32'h0000_00F0));
        vecs.push_back(mk(1'b0, F3_LHU, 32'h0000_0202, 32'h0,         32'h12F0_3456, 0, 0, 1'b0, 4'b0000, 32'h0, 32'h0000_12F0));
        vecs.push_back(mk(1'b0, F3_LH,  32'h0000_0200, 32'h0,         32'h0000_8001, 1, 1, 1'b0, 4'b0000, 32'h0, 32'hFFFF_8001));
        vecs.push_back(mk(1'b0, F3_LB,  32'h0000_0201, 32'h0,         32'h0000_7F00, 0, 0, 1'b0, 4'b0000, 32'h0, 32'h0000_007F));
        vecs.push_back(mk(1'b0, F3_LW,  32'h0000_0101, 32'h0,         32'h0,         0, 0, 1'b1, 4'b0000, 32'h0, 32'h0));
        vecs.push_back(mk(1'b0, F3_LW,  32'h0000_0204, 32'h0,         32'hCAFE_F00D, 0, 0, 1'b0, 4'b0000, 32'h0, 32'hCAFE_F00D));
        vecs.push_back(mk(1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,         0, 0, 1'b1, 4'b0000, 32'h0, 32'h0));
        vecs.push_back(mk(1'b0, F3_LW,  32'h0000_0208, 32'h0,         32'h0BAD_F00D, 1, 0, 1'b0, 4'b0000, 32'h0, 32'h0BAD_F00D));
        vecs.push_back(mk(1'b1, F3_SH,  32'h0000_0101, 32'h0000_1234, 32'h0,         0, 0, 1'b1, 4'b0000, 32'h0, 32'h0));
        vecs.push_back(mk(1'b1, 3'b110, 32'h0000_0100, 32'h0000_1234, 32'h0,         0, 0, 1'b1, 4'b0000, 32'h0, 32'h0));
        vecs.push_back(mk(1'b0, F3_LHU, 32'h0000_0200, 32'h0,         32'h1234_ABCD, 0, 3, 1'b0, 4'b0000, 32'h0, 32'h0000_ABCD));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Watchdog: gnt never comes; read_data must drop from ABCD to 0.
        @(negedge clk);
        req_valid = 1'b1; mem_w = 1'b0; funct3 = F3_LW; addr = 32'h0000_0300;
        #1;
        check("to_stall_req", 32'(stall), 32'h1);
        @(negedge clk);
        req_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (dbg_state == DONE) break;
            if (bus_req) req_cnt++;
            @(negedge clk);
        end
        exp_rd = 32'h0;
        check("to_state_done", 32'(dbg_state), 32'(DONE));
        check("to_req_cycles", 32'(req_cnt), 32'(TO));
        check("to_access_err", 32'(access_err), 32'h1);
        check("to_stall_released", 32'(stall), 32'h0);
        check("to_bus_req_low", 32'(bus_req), 32'h0);
        check("to_read_data", read_data, exp_rd);
        req_valid = 1'b0;
        @(negedge clk);
        check("to_idle", 32'(dbg_state), 32'(IDLE));
        check("to_err_pulse_end", 32'(access_err), 32'h0);
        bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h5555_5555;
        check("late_gnt_state", 32'(dbg_state), 32'(IDLE));
        check("late_gnt_read_data", read_data, exp_rd);
        check("late_gnt_bus_req", 32'(bus_req), 32'h0);

        // Reset while a load waits for data, with an orphan rvalid during reset.
        @(negedge clk);
        req_valid = 1'b1; mem_w = 1'b0; funct3 = F3_LB; addr = 32'h0000_0202;
        @(negedge clk);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        check("rst_mid_in_wait", 32'(dbg_state), 32'(WAIT));
        check("rst_mid_stall_before", 32'(stall), 32'h1);
        srst = 1'b1; req_valid = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        #1;
        check("rst_mid_bus_req", 32'(bus_req), 32'h0);
        check("rst_mid_stall", 32'(stall), 32'h0);
        check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        srst = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h5555_5555;
        exp_rd = 32'h0;
        check("rst_mid_read_data", read_data, exp_rd);
        run_vec(mk(1'b0, F3_LW, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0, 4'b0000, 32'h0, 32'hCAFE_F00D));

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the single-cycle datapath and a handshaked data-memory bus. Takes the datapath's effective address (ALU result), store data (register-file RD2) and the controller's memory strobes. Drives a word-aligned bus request with byte enables, and returns sign/zero-extended load data on the datapath's read-data input. While a bus access is in flight it stalls the core (PC and register write held).

## Interface
- TIMEOUT, default 255: max cycles waiting for bus_gnt/bus_rvalid before aborting with error; 0 disables the watchdog.
- clk  input  1  clock; all state on rising edge
- srst  input  1  reset, asynchronous, active-high
- req_valid  input  1  current instruction is a load or store
- mem_w  input  1  1 = store, 0 = load
- funct3  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  input  32  effective byte address
- wdata  input  32  store data, value in low bits
- read_data  output  32  extended load result, registered
- stall  output  1  core must hold PC/instr and suppress reg write
- access_err  output  1  one-cycle pulse: misaligned, illegal funct3, or timeout
- bus_req  output  1  request valid, held until bus_gnt
- bus_we  output  1  write request
- bus_addr  output  32  {addr[31:2],2'b00}
- bus_be  output  4  byte enables
- bus_wdata  output  32  lane-replicated store data
- bus_gnt  input  1  request accepted this cycle
- bus_rvalid  input  1  load data valid (same cycle as gnt or later)
- bus_rdata  input  32  load word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: on req_valid, check the access. Misaligned = H/HU with addr[0]=1, or W with addr[1:0]≠0. Illegal = funct3 ∈ {011,110,111}.
  - Bad access: pulse access_err, read_data←0, stay IDLE, stall=0, no bus activity. Same rule for illegal funct3 with mem_w=1.
  - Good access: go REQ; latch addr[1:0], funct3, mem_w, be, lane data.
- REQ: bus_req=1.
  - bus_gnt & store → DONE.
  - bus_gnt & load & bus_rvalid → capture, DONE.
  - bus_gnt & load & !bus_rvalid → WAIT.
- WAIT: bus_rvalid → capture, DONE.
- DONE: stall=0 for one cycle so the core retires; always → IDLE. A req_valid seen in DONE is not re-issued.
- Store lanes:
  - B: be=0001<<addr[1:0], data {4{wdata[7:0]}}.
  - H: be=0011<<{addr[1],1'b0}, data {2{wdata[15:0]}}.
  - W: be=1111, data wdata.
- Load extract: select the byte/half by latched addr[1:0]; sign-extend for B/H, zero-extend for BU/HU; W passes through. Result registered into read_data on capture.
- Watchdog: counter cleared on entering REQ, increments each cycle in REQ/WAIT. On reaching TIMEOUT: access_err pulse, read_data←0, bus_req drops, → DONE. A late bus_rvalid after abort is ignored.

## Timing
- stall = (IDLE & req_valid & good access) | REQ | WAIT. It is combinational so it blocks the PC update in the request cycle.
- Minimum latency, gnt+rvalid in first REQ cycle: request cycle (IDLE), REQ, DONE = 3 cycles; instruction retires at the DONE edge.
- bus_req, bus_we, bus_addr, bus_be and bus_wdata are registered. They are stable from REQ entry until the gnt cycle and change only then.
- access_err is registered: high the cycle after detection, or in DONE for timeout.
- Reset values: state IDLE, read_data 0, bus_req 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, access_err 0, counter 0, so stall 0.
- Reset mid-transaction clears everything immediately. The transaction is abandoned; the bus side must tolerate an orphaned gnt/rvalid, which is ignored.

## Structure
- Shared riscv_pkg holds:
  - lsu_state_e (IDLE/REQ/WAIT/DONE).
  - funct3 constants F3_LB/LH/LW/LBU/LHU, with SB/SH/SW aliasing the low three.
  - Function is_misaligned(funct3, addr[1:0]).
- Sub-module lsu_align, purely combinational: store lane steering (be, bus_wdata) and load extraction/extension, from funct3, addr[1:0], wdata and rdata.
- Top level holds the FSM, latches and watchdog.

## Test plan
- SW addr 0x100 wdata 0xDEADBEEF, gnt in first REQ → bus_be 1111, bus_wdata 0xDEADBEEF, bus_addr 0x100, stall high 2 cycles, DONE on cycle 3.
- SB addr 0x103 wdata 0x000000A5 → bus_be 1000, bus_wdata 0xA5A5A5A5, bus_addr 0x100.
- LB addr 0x202, rdata 0x12F03456, rvalid 2 cycles after gnt → read_data 0xFFFFFFF0; repeat with LBU → 0x000000F0; LHU addr 0x202 → 0x000012F0.
- LW addr 0x101 → access_err pulse, no bus_req, stall never asserted, read_data 0; funct3=011 gives the same response.
- TIMEOUT=4, bus_gnt held low → bus_req high 4 cycles, then access_err, DONE, stall released; a gnt arriving later is ignored.
- srst asserted in WAIT → bus_req and stall low in the same cycle, state IDLE; a subsequent LW completes normally.
